// File: rtl/alu_pkg.sv
// Shared definitions for the mtm_Alu serial link.
// Holds the opcode and frame-type enums, the error-bit layout, the default
// packet length and the CRC4 step function. The host-side serialiser uses
// the same crc4_next, so both ends of the link agree bit for bit.
package alu_pkg;

  typedef enum logic [2:0] {
    OP_AND = 3'b000,
    OP_OR  = 3'b001,
    OP_ADD = 3'b100,
    OP_SUB = 3'b101
  } op_t;

  typedef enum logic {
    FRAME_DATA = 1'b0,
    FRAME_CMD  = 1'b1
  } frame_type_t;

  // Bit positions inside out_err = {ERR_DATA, ERR_CRC, ERR_OP}
  localparam int ERR_DATA = 2;
  localparam int ERR_CRC  = 1;
  localparam int ERR_OP   = 0;

  localparam logic [2:0] ERR_MASK_DATA = 3'b100;

  localparam int DATA_FRAMES_DEFAULT = 8;

  // One serial step of CRC4, polynomial x^4+x+1, MSB first.
  function automatic logic [3:0] crc4_next(input logic [3:0] crc, input logic d);
    logic fb;
    fb = crc[3] ^ d;
    return {crc[2:0], 1'b0} ^ (fb ? 4'b0011 : 4'b0000);
  endfunction

  function automatic logic op_is_valid(input logic [2:0] op);
    case (op)
      OP_AND, OP_OR, OP_ADD, OP_SUB: return 1'b1;
      default:                       return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mtm_alu_frame_rx.sv
// Bit-level receiver for one 11-bit frame: start(0), type, payload[7:0]
// MSB first, stop(1). One bit is sampled per rising clk.
// Ports:
//   clk, rst     clock, asynchronous active-high reset
//   sin          serial input, idles high
//   frame_valid  pulses while the good stop bit is being sampled
//   frame_type   type bit of the current frame
//   frame_byte   payload of the current frame
//   frame_err    pulses while a bad (low) stop bit is being sampled
//
// state     | meaning
// ----------+------------------------------------------------
// IDLE      | line high, waiting for a start bit
// TYPE      | sampling the type bit
// PAYLOAD   | shifting in payload bits, bit_cnt counts 0..7
// STOP      | sampling the stop bit
// WAIT_HIGH | framing error seen, waiting for line to return high
module mtm_alu_frame_rx
  import alu_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        sin,
  output logic        frame_valid,
  output frame_type_t frame_type,
  output logic [7:0]  frame_byte,
  output logic        frame_err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_TYPE,
    S_PAYLOAD,
    S_STOP,
    S_WAIT_HIGH
  } state_t;

  state_t     state, state_next;
  logic [2:0] bit_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      bit_cnt    <= 3'd0;
      frame_type <= FRAME_DATA;
      frame_byte <= 8'd0;
    end else begin
      state <= state_next;
      case (state)
        S_TYPE: begin
          frame_type <= sin ? FRAME_CMD : FRAME_DATA;
          bit_cnt    <= 3'd0;
        end
        S_PAYLOAD: begin
          frame_byte <= {frame_byte[6:0], sin};
          bit_cnt    <= bit_cnt + 3'd1;
        end
        default: ;
      endcase
    end
  end

  // frame_valid/frame_err are Mealy outputs on the stop bit so the packet
  // layer can register its strobe on that same edge.
  always_comb begin
    state_next  = state;
    frame_valid = 1'b0;
    frame_err   = 1'b0;
    case (state)
      S_IDLE:      if (!sin) state_next = S_TYPE;
      S_TYPE:      state_next = S_PAYLOAD;
      S_PAYLOAD:   if (bit_cnt == 3'd7) state_next = S_STOP;
      S_STOP: begin
        if (sin) begin
          frame_valid = 1'b1;
          state_next  = S_IDLE;
        end else begin
          frame_err  = 1'b1;
          state_next = S_WAIT_HIGH;
        end
      end
      S_WAIT_HIGH: if (sin) state_next = S_IDLE;
      default:     state_next = S_IDLE;
    endcase
  end

endmodule

// File: rtl/mtm_alu_deserializer.sv
// ALU-side packet receiver for the mtm_Alu link. Collects DATA_FRAMES data
// bytes (B then A, MSB byte first) and one cmd frame {0, op, crc}, checks
// frame count, CRC4 and opcode, and emits a one-cycle strobe per packet.
// Ports:
//   clk, rst   clock, asynchronous active-high reset
//   sin        serial input, idles high
//   out_valid  one-cycle strobe: request or error available
//   out_b      operand B
//   out_a      operand A
//   out_op     opcode
//   out_err    {ERR_DATA, ERR_CRC, ERR_OP}, at most one bit set
module mtm_alu_deserializer
  import alu_pkg::*;
#(
  parameter int DATA_FRAMES = DATA_FRAMES_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sin,
  output logic        out_valid,
  output logic [31:0] out_b,
  output logic [31:0] out_a,
  output logic [2:0]  out_op,
  output logic [2:0]  out_err
);

  localparam int CNT_W = $clog2(DATA_FRAMES + 2);
  localparam int BA_W  = DATA_FRAMES * 8;
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DATA_FRAMES);
  localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(DATA_FRAMES + 1);

  logic              frame_valid;
  frame_type_t       frame_type;
  logic [7:0]        frame_byte;
  logic              frame_err;

  logic [BA_W-1:0]   ba;
  logic [CNT_W-1:0]  frame_cnt;
  logic [3:0]        crc;
  logic [3:0]        crc_cmd;
  logic [2:0]        err_cmd;

  function automatic logic [3:0] crc4_byte(input logic [3:0] c, input logic [7:0] b);
    logic [3:0] r;
    r = c;
    for (int i = 7; i >= 0; i--) r = crc4_next(r, b[i]);
    return r;
  endfunction

  mtm_alu_frame_rx u_frame_rx (
    .clk         (clk),
    .rst         (rst),
    .sin         (sin),
    .frame_valid (frame_valid),
    .frame_type  (frame_type),
    .frame_byte  (frame_byte),
    .frame_err   (frame_err)
  );

  // Close the CRC over the trailing {1'b1, op} bits carried in the cmd frame.
  always_comb begin
    crc_cmd = crc4_next(crc, 1'b1);
    crc_cmd = crc4_next(crc_cmd, frame_byte[6]);
    crc_cmd = crc4_next(crc_cmd, frame_byte[5]);
    crc_cmd = crc4_next(crc_cmd, frame_byte[4]);
  end

  always_comb begin
    err_cmd = 3'b000;
    if (frame_cnt != CNT_FULL)             err_cmd[ERR_DATA] = 1'b1;
    else if (crc_cmd != frame_byte[3:0])   err_cmd[ERR_CRC]  = 1'b1;
    else if (!op_is_valid(frame_byte[6:4])) err_cmd[ERR_OP]  = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_b     <= 32'd0;
      out_a     <= 32'd0;
      out_op    <= 3'd0;
      out_err   <= 3'd0;
      ba        <= '0;
      frame_cnt <= '0;
      crc       <= 4'd0;
    end else begin
      out_valid <= 1'b0;
      if (frame_err) begin
        out_valid <= 1'b1;
        out_err   <= ERR_MASK_DATA;
        frame_cnt <= '0;
        crc       <= 4'd0;
      end else if (frame_valid) begin
        if (frame_type == FRAME_DATA) begin
          ba  <= {ba[BA_W-9:0], frame_byte};
          crc <= crc4_byte(crc, frame_byte);
          if (frame_cnt != CNT_SAT) frame_cnt <= frame_cnt + CNT_W'(1);
        end else begin
          out_valid <= 1'b1;
          out_err   <= err_cmd;
          out_b     <= ba[BA_W-1 -: 32];
          out_a     <= ba[31:0];
          out_op    <= frame_byte[6:4];
          frame_cnt <= '0;
          crc       <= 4'd0;
        end
      end
    end
  end

endmodule

// File: tb/tb_mtm_alu_deserializer.sv
module tb_mtm_alu_deserializer;

  logic        clk = 1'b0;
  logic        rst;
  logic        sin;
  logic        out_valid;
  logic [31:0] out_b;
  logic [31:0] out_a;
  logic [2:0]  out_op;
  logic [2:0]  out_err;

  int n_checks = 0;
  int n_err    = 0;
  int strobes  = 0;

  mtm_alu_deserializer dut (
    .clk       (clk),
    .rst       (rst),
    .sin       (sin),
    .out_valid (out_valid),
    .out_b     (out_b),
    .out_a     (out_a),
    .out_op    (out_op),
    .out_err   (out_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (out_valid === 1'b1) strobes = strobes + 1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks = n_checks + 1;
    if (got !== exp) begin
      n_err = n_err + 1;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference CRC4 over the whole 68-bit message {B, A, 1, op}.
  function automatic logic [3:0] crc_ref(input logic [67:0] m);
    logic [3:0] c;
    logic       fb;
    c = 4'd0;
    for (int i = 67; i >= 0; i--) begin
      fb = c[3] ^ m[i];
      c  = {c[2:0], 1'b0} ^ {2'b00, fb, fb};
    end
    return c;
  endfunction

  function automatic logic [7:0] cmd_byte(input logic [31:0] b, input logic [31:0] a,
                                          input logic [2:0] op);
    return {1'b0, op, crc_ref({b, a, 1'b1, op})};
  endfunction

  task automatic send_frame(input logic typ, input logic [7:0] pl, input logic stop);
    @(negedge clk) sin = 1'b0;
    @(negedge clk) sin = typ;
    for (int i = 7; i >= 0; i--) begin
      @(negedge clk) sin = pl[i];
    end
    @(negedge clk) sin = stop;
  endtask

  task automatic send_packet(input string tag, input logic [31:0] b, input logic [31:0] a,
                             input logic [7:0] cmd, input int nframes,
                             input logic [2:0] exp_err);
    logic [63:0] ba;
    int          s0;
    ba = {b, a};
    s0 = strobes;
    for (int i = 0; i < nframes; i++) send_frame(1'b0, ba[63-8*i -: 8], 1'b1);
    send_frame(1'b1, cmd, 1'b1);
    @(posedge clk); #1;
    chk({tag, "_valid"}, 64'(out_valid), 64'd1);
    chk({tag, "_err"},   64'(out_err),   64'(exp_err));
    if (exp_err == 3'b000) begin
      chk({tag, "_b"},  64'(out_b),  64'(b));
      chk({tag, "_a"},  64'(out_a),  64'(a));
      chk({tag, "_op"}, 64'(out_op), 64'(cmd[6:4]));
    end
    @(posedge clk); #1;
    chk({tag, "_one_cycle"}, 64'(out_valid), 64'd0);
    chk({tag, "_strobes"},   64'(strobes),   64'(s0 + 1));
  endtask

  initial begin
    int s0;
    rst = 1'b1;
    sin = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_err",   64'(out_err),   64'd0);
    chk("rst_b",     64'(out_b),     64'd0);
    chk("rst_a",     64'(out_a),     64'd0);
    chk("rst_op",    64'(out_op),    64'd0);
    @(negedge clk) rst = 1'b0;
    repeat (2) @(negedge clk);

    send_packet("good_and", 32'h0, 32'h0, 8'h0B, 8, 3'b000);
    send_packet("bad_crc",  32'h0, 32'h0, 8'h0A, 8, 3'b010);
    send_packet("bad_op",   32'h0, 32'h0, 8'h2D, 8, 3'b001);
    send_packet("short",    32'h0, 32'h0, 8'h0B, 7, 3'b100);
    send_packet("recover",  32'h0, 32'h0, 8'h0B, 8, 3'b000);

    // Framing error in data frame 3, line held low, then a good packet.
    s0 = strobes;
    send_frame(1'b0, 8'h11, 1'b1);
    send_frame(1'b0, 8'h22, 1'b1);
    send_frame(1'b0, 8'h55, 1'b0);
    @(posedge clk); #1;
    chk("frm_valid", 64'(out_valid), 64'd1);
    chk("frm_err",   64'(out_err),   64'b100);
    repeat (5) @(negedge clk) sin = 1'b0;
    @(negedge clk) sin = 1'b1;
    repeat (2) @(negedge clk);
    chk("frm_strobes", 64'(strobes), 64'(s0 + 1));
    send_packet("frm_good", 32'hA5A5_0F0F, 32'h00C3_1234,
                cmd_byte(32'hA5A5_0F0F, 32'h00C3_1234, 3'b001), 8, 3'b000);

    // Reset pulse in the middle of frame 5.
    s0 = strobes;
    for (int i = 0; i < 4; i++) send_frame(1'b0, 8'hC0 + 8'(i), 1'b1);
    @(negedge clk) sin = 1'b0;
    @(negedge clk) sin = 1'b0;
    repeat (3) @(negedge clk) sin = 1'b1;
    @(negedge clk);
    rst = 1'b1;
    sin = 1'b1;
    #1;
    chk("arst_b",  64'(out_b),  64'd0);
    chk("arst_a",  64'(out_a),  64'd0);
    chk("arst_op", 64'(out_op), 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    chk("arst_no_strobe", 64'(strobes), 64'(s0));
    send_packet("post_rst", 32'h1234_5678, 32'hDEAD_BEEF,
                cmd_byte(32'h1234_5678, 32'hDEAD_BEEF, 3'b100), 8, 3'b000);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
